input_debouncer: RTL and testbench

- Upstream conditioning stage for the D flip-flop/latch block. Takes a raw, asynchronous, bouncing board input (switch or button), synchronizes it to clk_i, and accepts a level change only after it has been stable for STABLE_CYCLES consecutive clocks.
- Produces a clean data level d_o plus a one-cycle strobe e_o, intended to drive the latch's d_i/e_i. Also produces rise_o and fall_o edge pulses for other consumers.

---
 rtl/input_debouncer_pkg.sv | 25 ++
 rtl/input_debouncer_sync.sv | 36 +++
 rtl/input_debouncer.sv | 141 ++++++++++++++
 tb/tb_input_debouncer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the board-input debouncer.
//   deb_state_t        : 2-bit FSM state encoding (IDLE_LOW=0, WAIT_HIGH=1,
//                        IDLE_HIGH=2, WAIT_LOW=3)
//   DEB_SYNC_STAGES    : default synchronizer depth
//   DEB_STABLE_CYCLES  : default number of stable samples to accept a change
//   deb_level          : debounced level implied by a state
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_t;

  localparam int DEB_SYNC_STAGES   = 2;
  localparam int DEB_STABLE_CYCLES = 16;

  // The accepted level is high while settled high or while qualifying a
  // possible fall; a candidate change does not move the level.
  function automatic logic deb_level(input deb_state_t st);
    return (st == IDLE_HIGH) || (st == WAIT_LOW);
  endfunction

endpackage

// File: rtl/input_debouncer_sync.sv
// bit_sync: resettable multi-flop synchronizer for one asynchronous bit.
// Reusable for any board input that must be brought into the clk_i domain.
// Ports:
//   clk_i    : destination clock, rising edge
//   rst_n_i  : synchronous active-low reset, clears every stage to 0
//   d_i      : asynchronous input bit
//   q_o      : synchronized bit (last stage of the chain)
// STAGES must be at least 2.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift toward the MSB; only stage 0 ever samples the asynchronous input.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a bouncing board input and accepts a level
// change only after STABLE_CYCLES consecutive identical synchronized samples.
// Ports:
//   clk_i    : system clock, rising edge
//   rst_n_i  : synchronous active-low reset
//   raw_i    : asynchronous raw switch/button input
//   d_o      : debounced level (registered)
//   e_o      : one-cycle strobe in the cycle d_o takes a new value
//   rise_o   : one-cycle pulse on an accepted 0->1 change
//   fall_o   : one-cycle pulse on an accepted 1->0 change
//   busy_o   : high while a candidate change is being qualified
// Parameters: SYNC_STAGES in 2..4, STABLE_CYCLES >= 2,
// 2**CNT_W > STABLE_CYCLES.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
  parameter int CNT_W         = 5
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic d_o,
  output logic e_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       s;
  deb_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic d_q, d_d;
  logic e_q, e_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic busy_q, busy_d;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (raw_i),
    .q_o     (s)
  );

  // Next state and stability counter. The counter holds the number of
  // consecutive candidate samples seen so far; the sample that leaves IDLE
  // counts as the first, so commit happens on sample STABLE_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Output registers follow the state register by one cycle. Edge pulses
  // are derived by comparing the new level against the registered one, so
  // e_o/rise_o/fall_o line up exactly with the cycle d_o changes.
  always_comb begin
    d_d    = deb_level(state_q);
    rise_d = d_d & ~d_q;
    fall_d = ~d_d & d_q;
    e_d    = rise_d | fall_d;
    busy_d = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      e_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      e_q     <= e_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign d_o    = d_q;
  assign e_o    = e_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer. Each accepted level change is
// predicted when raw_i is driven (edge index of the expected pulse plus its
// direction) and pushed to exp_q; every observed pulse pops and compares.
module tb_input_debouncer;
  import debounce_pkg::*;

  localparam int LAT = DEB_SYNC_STAGES + DEB_STABLE_CYCLES;
  localparam int W   = 34;

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic raw_i;
  logic d_o, e_o, rise_o, fall_o, busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0, t1;
  logic exp_d = 1'b0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  input_debouncer dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .raw_i   (raw_i),
    .d_o     (d_o),
    .e_o     (e_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .busy_o  (busy_o)
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record {edge index, rise, fall} of a predicted pulse.
  task automatic expect_edge(input int at, input logic rise);
    exp_q.push_back({32'(at), rise, ~rise});
  endtask

  // ---------------- driver ----------------
  // One clock: sample #1 after the edge, check pulses against the queue and
  // the level against the level implied by the last popped pulse.
  task automatic tick();
    logic [W-1:0] item;
    @(posedge clk_i);
    #1;
    chk("rise_fall_excl", W'(rise_o & fall_o), '0);
    chk("e_is_or", W'(e_o), W'(rise_o | fall_o));
    if (e_o === 1'b1 || rise_o === 1'b1 || fall_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {32'(cyc), rise_o, fall_o}, '0);
      end else begin
        item = exp_q.pop_front();
        chk("pulse", {32'(cyc), rise_o, fall_o}, item);
        exp_d = item[1];
      end
    end
    chk("d_level", W'(d_o), W'(exp_d));
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held 3 cycles with raw high: everything stays quiet.
    rst_n_i = 1'b0;
    raw_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy", W'(busy_o), '0);
      chk("rst_e", W'(e_o), '0);
      chk("rst_d", W'(d_o), '0);
    end

    // Release reset with raw high: rise LAT edges later.
    rst_n_i = 1'b1;
    t0 = cyc;
    expect_edge(t0 + LAT, 1'b1);
    run(10);
    chk("post_rst_busy_mid", W'(busy_o), W'(1'b1));
    run(20);
    chk("post_rst_busy_end", W'(busy_o), '0);
    chk("post_rst_q_empty", W'(exp_q.size()), '0);
    chk("post_rst_d", W'(d_o), W'(1'b1));

    // Release: fall LAT edges after raw drops.
    raw_i = 1'b0;
    t0 = cyc;
    expect_edge(t0 + LAT, 1'b0);
    run(20);
    chk("release_q_empty", W'(exp_q.size()), '0);
    chk("release_d", W'(d_o), '0);

    // Clean press held 30 cycles.
    raw_i = 1'b1;
    t0 = cyc;
    expect_edge(t0 + LAT, 1'b1);
    run(8);
    chk("press_busy_mid", W'(busy_o), W'(1'b1));
    chk("press_d_mid", W'(d_o), '0);
    run(22);
    chk("press_q_empty", W'(exp_q.size()), '0);
    chk("press_busy_end", W'(busy_o), '0);

    raw_i = 1'b0;
    t0 = cyc;
    expect_edge(t0 + LAT, 1'b0);
    run(20);
    chk("release2_q_empty", W'(exp_q.size()), '0);

    // Bounce 1,0,1,0 at 3 cycles per level, then settle high.
    for (int i = 0; i < 4; i++) begin
      raw_i = (i % 2 == 0);
      run(3);
    end
    chk("bounce_d", W'(d_o), '0);
    raw_i = 1'b1;
    t0 = cyc;
    expect_edge(t0 + LAT, 1'b1);
    run(25);
    chk("bounce_q_empty", W'(exp_q.size()), '0);
    chk("bounce_d_final", W'(d_o), W'(1'b1));

    raw_i = 1'b0;
    t0 = cyc;
    expect_edge(t0 + LAT, 1'b0);
    run(20);
    chk("release3_q_empty", W'(exp_q.size()), '0);

    // Glitch one sample short of acceptance: rejected.
    raw_i = 1'b1;
    run(10);
    chk("glitch_busy", W'(busy_o), W'(1'b1));
    run(DEB_STABLE_CYCLES - 1 - 10);
    raw_i = 1'b0;
    run(6);
    chk("glitch_busy_end", W'(busy_o), '0);
    chk("glitch_d", W'(d_o), '0);
    run(10);

    // Exactly STABLE_CYCLES high: accepted, then released.
    raw_i = 1'b1;
    t0 = cyc;
    expect_edge(t0 + LAT, 1'b1);
    run(DEB_STABLE_CYCLES);
    raw_i = 1'b0;
    t1 = cyc;
    expect_edge(t1 + LAT, 1'b0);
    run(25);
    chk("exact_q_empty", W'(exp_q.size()), '0);
    chk("exact_d", W'(d_o), '0);

    // Reset in the middle of a qualification discards it.
    raw_i = 1'b1;
    run(10);
    chk("midwait_busy", W'(busy_o), W'(1'b1));
    rst_n_i = 1'b0;
    tick();
    chk("midwait_rst_busy", W'(busy_o), '0);
    chk("midwait_rst_cnt", W'(dut.cnt_q), '0);
    chk("midwait_rst_state", W'(dut.state_q), W'(IDLE_LOW));
    rst_n_i = 1'b1;
    t0 = cyc;
    expect_edge(t0 + LAT, 1'b1);
    run(25);
    chk("midwait_q_empty", W'(exp_q.size()), '0);
    chk("midwait_d", W'(d_o), W'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
